// File: rtl/cordic_engine.sv
// Iterative CORDIC (rotation; vectoring when CORDIC_VECTOR_EN is defined), one op in flight.
// Latency: out_valid N_ITER+2 cycles after accept; result held until out_ready, in_ready only when idle.
module cordic_engine #(
  parameter int WL     = 16,
  parameter int FL     = 13,
  parameter int N_ITER = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [WL-1:0] in_x,
  input  logic [WL-1:0] in_y,
  input  logic [WL-1:0] in_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mode,
  output logic [WL-1:0] out_x,
  output logic [WL-1:0] out_y,
  output logic [WL-1:0] out_z
);

  localparam int AW = WL + 2;
  localparam int SH = 30 - FL;
  localparam logic [63:0] RND = 64'd1 << (SH - 1);
  localparam logic signed [AW-1:0] HALF_PI = AW'((64'd1686629713 + RND) >> SH);
  localparam logic signed [AW-1:0] SMAX = AW'((64'd1 << (WL - 1)) - 64'd1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic [4:0] LAST = 5'(N_ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // atan(2^-i) in Q2.30
  function automatic logic [31:0] atan_q30(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_q30 = 32'd843314857;
      5'd1:  atan_q30 = 32'd497837829;
      5'd2:  atan_q30 = 32'd263043837;
      5'd3:  atan_q30 = 32'd133525159;
      5'd4:  atan_q30 = 32'd67021687;
      5'd5:  atan_q30 = 32'd33543516;
      5'd6:  atan_q30 = 32'd16775851;
      5'd7:  atan_q30 = 32'd8388437;
      5'd8:  atan_q30 = 32'd4194283;
      5'd9:  atan_q30 = 32'd2097149;
      5'd31: atan_q30 = 32'd0;
      default: atan_q30 = 32'd1 << (30 - idx);
    endcase
  endfunction

  function automatic logic [WL-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SMAX)      sat = SMAX[WL-1:0];
    else if (v < SMIN) sat = SMIN[WL-1:0];
    else               sat = v[WL-1:0];
  endfunction

  logic [1:0]           r_state;
  logic [4:0]           r_i;
  logic signed [AW-1:0] r_x, r_y, r_z;
  logic                 r_out_valid;
  logic [WL-1:0]        r_out_x, r_out_y, r_out_z;
  logic signed [AW-1:0] w_atan, w_xs, w_ys;
  logic                 w_d;

  assign w_atan = AW'(({32'd0, atan_q30(r_i)} + RND) >> SH);
  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;

`ifdef CORDIC_VECTOR_EN
  logic r_mode, r_out_mode;
  assign w_d      = r_mode ? r_y[AW-1] : ~r_z[AW-1];
  assign out_mode = r_out_mode;
`else
  logic w_unused;
  assign w_unused = in_mode;
  assign w_d      = ~r_z[AW-1];
  assign out_mode = 1'b0;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
`ifdef CORDIC_VECTOR_EN
      r_mode      <= 1'b0;
      r_out_mode  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x     <= {{2{in_x[WL-1]}}, in_x};
          r_y     <= {{2{in_y[WL-1]}}, in_y};
          r_z     <= {{2{in_z[WL-1]}}, in_z};
          r_i     <= '0;
          r_state <= S_PRE;
`ifdef CORDIC_VECTOR_EN
          r_mode  <= in_mode;
`endif
        end
        S_PRE: begin
          // Fold the input into the +-pi/2 convergence range of the iterations
`ifdef CORDIC_VECTOR_EN
          if (r_mode) begin
            if (r_x[AW-1] && !r_y[AW-1]) begin
              r_x <= r_y;  r_y <= -r_x;  r_z <= HALF_PI;
            end else if (r_x[AW-1]) begin
              r_x <= -r_y; r_y <= r_x;   r_z <= -HALF_PI;
            end else begin
              r_z <= '0;
            end
          end else
`endif
          begin
            if (r_z > HALF_PI) begin
              r_x <= -r_y; r_y <= r_x;  r_z <= r_z - HALF_PI;
            end else if (r_z < -HALF_PI) begin
              r_x <= r_y;  r_y <= -r_x; r_z <= r_z + HALF_PI;
            end
          end
          r_state <= S_ROT;
        end
        S_ROT: begin
          r_x <= w_d ? r_x - w_ys : r_x + w_ys;
          r_y <= w_d ? r_y + w_xs : r_y - w_xs;
          r_z <= w_d ? r_z - w_atan : r_z + w_atan;
          r_i <= r_i + 5'd1;
          if (r_i == LAST) r_state <= S_OUT;
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_x     <= sat(r_x);
            r_out_y     <= sat(r_y);
            r_out_z     <= r_z[WL-1:0];
`ifdef CORDIC_VECTOR_EN
            r_out_mode  <= r_mode;
`endif
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine (WL=16, FL=13, N_ITER=15); expectations follow CORDIC_VECTOR_EN.
module tb_cordic_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [15:0] in_x, in_y, in_z;
  logic        out_valid, out_ready, out_mode;
  logic [15:0] out_x, out_y, out_z;

  int checks = 0;
  int errors = 0;
  int lat;
  int sx, sz;

  always #5 clk = ~clk;

  cordic_engine #(.WL(16), .FL(13), .N_ITER(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= tol) === 1'b1)
      else begin
        errors++;
        $error("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
  endtask

  task automatic send(input logic m, input int x, input int y, input int z);
    chk("in_ready_before_accept", int'(in_ready), 1, 0);
    in_valid = 1'b1; in_mode = m;
    in_x = 16'(x); in_y = 16'(y); in_z = 16'(z);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = ~m;
    in_x = 16'h5a5a; in_y = 16'ha5a5; in_z = 16'h1234;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_pop", int'(out_valid), 0, 0);
    chk("in_ready_after_pop", int'(in_ready), 1, 0);
  endtask

  task automatic chk_res(input string tag, input int ex, input int ey, input int ez, input int em);
    chk({tag, "_x"}, int'($signed(out_x)), ex, 6);
    chk({tag, "_y"}, int'($signed(out_y)), ey, 6);
    chk({tag, "_z"}, int'($signed(out_z)), ez, 6);
    chk({tag, "_mode"}, int'(out_mode), em, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain rotation by 0: gain only, latency check
    send(1'b0, 4974, 0, 0);
    wait_out(lat);
    chk("lat_rot0", lat, 17, 0);
    chk("busy_in_ready", int'(in_ready), 0, 0);
    chk_res("rot0", 8192, 0, 0, 0);
    pop();

    // Quadrant correction below -pi/2 and exactly at +pi/2
    send(1'b0, 4974, 0, -25736);
    wait_out(lat);
    chk("lat_rotm_pi", lat, 17, 0);
    chk_res("rot_mpi", -8192, 0, 0, 0);
    pop();

    send(1'b0, 4974, 0, 12868);
    wait_out(lat);
    chk_res("rot_pi2", 0, 8192, 0, 0);
    pop();

    // Vectoring requests (rotation by 0 when the feature is absent)
    send(1'b1, 8192, 8192, 0);
    wait_out(lat);
    chk("lat_vec", lat, 17, 0);
`ifdef CORDIC_VECTOR_EN
    chk_res("vec_45", 19078, 0, 6434, 1);
`else
    chk_res("vec_45", 13490, 13490, 0, 0);
`endif
    pop();

    send(1'b1, -8192, 0, 0);
    wait_out(lat);
`ifdef CORDIC_VECTOR_EN
    chk_res("vec_180", 13490, 0, 25736, 1);
`else
    chk_res("vec_180", -13490, 0, 0, 0);
`endif
    pop();

    // Saturation, then hold the result under backpressure with a competing request
    send(1'b0, 19000, 19000, 6434);
    wait_out(lat);
    chk("sat_y", int'($signed(out_y)), 32767, 0);
    chk("sat_x", int'($signed(out_x)), 0, 6);
    sx = int'($signed(out_x));
    sz = int'($signed(out_z));
    in_valid = 1'b1; in_mode = 1'b0; in_x = 16'd100; in_y = 16'd200; in_z = 16'd300;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_out_valid", int'(out_valid), 1, 0);
    chk("bp_in_ready", int'(in_ready), 0, 0);
    chk("bp_y_hold", int'($signed(out_y)), 32767, 0);
    chk("bp_x_hold", int'($signed(out_x)), sx, 0);
    chk("bp_z_hold", int'($signed(out_z)), sz, 0);
    pop();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_not_queued", int'(out_valid), 0, 0);

    // Reset during iteration 7, then a fresh operation
    send(1'b0, 4974, 0, 6434);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_in_ready", int'(in_ready), 1, 0);
    chk_res("mid_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_result", int'(out_valid), 0, 0);
    send(1'b0, 4974, 0, 6434);
    wait_out(lat);
    chk("lat_after_rst", lat, 17, 0);
    chk_res("after_rst", 5792, 5792, 0, 0);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
